// File: rtl/event_pkg.sv
// event_pkg: shared record type, FSM states and widths for the event injector.
package event_pkg;
  localparam int NUM_INPUTS = 2;
  localparam int EV_TS_W = 32;
  localparam int EV_DATA_W = 32;
  typedef struct packed {
    logic [EV_TS_W-1:0] ts;
    logic [NUM_INPUTS-1:0] mask;
    logic [EV_DATA_W-1:0] x1;
    logic [EV_DATA_W-1:0] x2;
  } record_t;
  typedef enum logic [1:0] {EMPTY, WAIT, FIRE} state_t;
endpackage

// File: rtl/event_fifo.sv
// event_fifo: synchronous record FIFO with async flush.
module event_fifo
  import event_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  record_t din,
  output record_t dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  record_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic wr, rd;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign dout = mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_q] <= din;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (wr) wr_q <= wr_q + 1'b1;
      if (rd) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/event_injector.sv
// event_injector: replays timestamped host records as one-cycle monitor input events.
module event_injector
  import event_pkg::*;
#(
  parameter int DATA_W = EV_DATA_W,
  parameter int TS_W = EV_TS_W,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic in_valid,
  output logic in_ready,
  input  logic [TS_W-1:0] in_ts,
  input  logic [1:0] in_new,
  input  logic [DATA_W-1:0] in_x1,
  input  logic [DATA_W-1:0] in_x2,
  output logic [DATA_W-1:0] x1,
  output logic [DATA_W-1:0] x2,
  output logic newX1,
  output logic newX2,
  output logic [TS_W-1:0] time_now,
  output logic late,
  output logic ord_err
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t state_q, state_d;
  record_t rec, head;
  logic full, empty, push, pop;
  logic [CW-1:0] count;
  logic [TS_W-1:0] time_q, last_ts_q;
  logic [DATA_W-1:0] x1_q, x2_q;
  logic [1:0] new_q;
  logic late_q, ord_q, pend_q;
  assign rec = '{in_ts, in_new, in_x1, in_x2};
  assign in_ready = !full;
  assign push = in_valid && in_ready;
  assign pop = state_q == FIRE;
  event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(rec), .dout(head),
    .full(full), .empty(empty), .count(count)
  );
  always_comb begin
    state_d = state_q == EMPTY ? (empty ? EMPTY : WAIT) :
              state_q == WAIT  ? (en && head.ts <= time_q ? FIRE : WAIT) :
              (count != CW'(1) || push ? WAIT : EMPTY);
  end
  // lateness is judged at the WAIT decision, so an on-time record is not
  // flagged just because the counter moved on during the FIRE stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      time_q <= '0;
      last_ts_q <= '0;
      x1_q <= '0;
      x2_q <= '0;
      new_q <= '0;
      late_q <= 1'b0;
      ord_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (en && time_q != '1) time_q <= time_q + 1'b1;
      new_q <= pop ? head.mask : 2'b00;
      if (pop && head.mask[0]) x1_q <= head.x1;
      if (pop && head.mask[1]) x2_q <= head.x2;
      if (state_q == WAIT) pend_q <= head.ts < time_q;
      if (pop) late_q <= late_q | pend_q;
      if (push) begin
        ord_q <= ord_q | (in_ts < last_ts_q);
        last_ts_q <= in_ts;
      end
    end
  end
  assign x1 = x1_q;
  assign x2 = x2_q;
  assign newX1 = new_q[0];
  assign newX2 = new_q[1];
  assign time_now = time_q;
  assign late = late_q;
  assign ord_err = ord_q;
endmodule
